// File: rtl/spi_dac_master_if.sv
// Command/response bundle between a register or stream front end and spi_dac_master.
// Latency: n/a (wires only). Backpressure: cmd_valid/cmd_ready handshake; rsp_valid is a one-cycle pulse with no ready.
// Ports: cmd_valid, cmd_data, cmd_sel (front end -> block); cmd_ready, rsp_valid, rsp_data, rsp_err (block -> front end).
interface spi_dac_master_if #(
    parameter int DATA_W = 24,
    parameter int SEL_W  = 1
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_data;
    logic [SEL_W-1:0]  cmd_sel;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_data, cmd_sel,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_sel,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/spi_dac_master.sv
// SPI master for serial DACs: one MSB-first frame per accepted command, miso captured into a readback word.
// Latency: accept to rsp_valid = CS_SETUP + (2*DATA_W-1)*CLK_DIV/2 + CS_HOLD cycles; ready again CS_IDLE cycles later.
// Backpressure: cmd_ready low from accept until the inter-frame gap ends; commands offered meanwhile are ignored.
// Ports: i_clk, i_reset (sync, active high); io_bus (command/response handshake);
//        o_busy; o_sclk, o_mosi, i_miso, o_cs_n (SPI pins; all outputs registered).
module spi_dac_master #(
    parameter int DATA_W   = 24,
    parameter int CLK_DIV  = 4,
    parameter bit CPOL     = 1'b0,
    parameter bit CPHA     = 1'b1,
    parameter int NUM_CS   = 1,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    spi_dac_master_if.slave    io_bus,
    output logic               o_busy,
    output logic               o_sclk,
    output logic               o_mosi,
    input  logic               i_miso,
    output logic [NUM_CS-1:0]  o_cs_n
);
    localparam int HALF     = CLK_DIV / 2;
    localparam int SEL_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int HW       = $clog2(HALF + 1);
    localparam int WAIT_MAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE)
                                                   : ((CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE);
    localparam int WW       = $clog2(WAIT_MAX + 1);
    localparam int EW       = $clog2(2 * DATA_W);
    localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_edge;
    logic              w_last;
    logic              w_done;
    logic [SEL_W-1:0]  w_sel;

    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;
    logic              r_sclk;
    logic              r_mosi;
    logic [NUM_CS-1:0] r_cs_n;
    logic [WW-1:0]     r_wait_cnt;
    logic [HW-1:0]     r_half_cnt;
    logic [EW-1:0]     r_edge;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic              r_err;

    assign w_sel  = io_bus.cmd_sel;
    assign w_last = (r_edge == EDGE_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // r_edge indexes the next sclk edge, so the edge that ends SETUP is simply edge 0.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_edge      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.cmd_valid && r_cmd_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (r_wait_cnt == '0) begin
                    w_edge      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_half_cnt == '0) begin
                    w_edge = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (r_wait_cnt == '0) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_wait_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_sclk      <= CPOL;
            r_mosi      <= 1'b0;
            r_cs_n      <= '1;
            r_wait_cnt  <= '0;
            r_half_cnt  <= '0;
            r_edge      <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_err       <= 1'b0;
        end else begin
            // Ready is a registered view of "next state is IDLE", so it rises one edge after reset or the gap.
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_rsp_valid <= w_done;

            if ((r_state == S_SETUP || r_state == S_HOLD || r_state == S_GAP) && r_wait_cnt != '0) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end
            if (r_state == S_SHIFT && r_half_cnt != '0) begin
                r_half_cnt <= r_half_cnt - 1'b1;
            end

            if (w_accept) begin
                r_tx       <= io_bus.cmd_data;
                r_mosi     <= io_bus.cmd_data[DATA_W-1];
                // An out-of-range index shifts the single zero out, leaving every select high.
                r_cs_n     <= ~(NUM_CS'(1) << w_sel);
                r_err      <= ({1'b0, w_sel} >= (SEL_W + 1)'(NUM_CS));
                r_edge     <= '0;
                r_wait_cnt <= WW'(CS_SETUP - 1);
            end

            if (w_edge) begin
                r_sclk <= ~r_sclk;
                if (w_last) begin
                    r_wait_cnt <= WW'(CS_HOLD - 1);
                end else begin
                    r_edge     <= r_edge + 1'b1;
                    r_half_cnt <= HW'(HALF - 1);
                end
                // Even edge index = leading edge. The launch side shifts r_tx so the next bit is always at a fixed position.
                if (r_edge[0] == 1'b0) begin
                    if (CPHA) begin
                        r_mosi <= r_tx[DATA_W-1];
                        r_tx   <= r_tx << 1;
                    end else begin
                        r_rx <= {r_rx[DATA_W-2:0], i_miso};
                    end
                end else begin
                    if (CPHA) begin
                        r_rx <= {r_rx[DATA_W-2:0], i_miso};
                    end else if (!w_last) begin
                        r_mosi <= r_tx[DATA_W-2];
                        r_tx   <= r_tx << 1;
                    end
                end
            end

            if (w_done) begin
                r_cs_n     <= '1;
                r_rsp_data <= r_rx;
                r_rsp_err  <= r_err;
                r_wait_cnt <= WW'(CS_IDLE - 1);
            end
        end
    end

    assign io_bus.cmd_ready = r_cmd_ready;
    assign io_bus.rsp_valid = r_rsp_valid;
    assign io_bus.rsp_data  = r_rsp_data;
    assign io_bus.rsp_err   = r_rsp_err;
    assign o_busy           = (r_state != S_IDLE);
    assign o_sclk           = r_sclk;
    assign o_mosi           = r_mosi;
    assign o_cs_n           = r_cs_n;
endmodule
